// File: rtl/garp_mem_bus_master.sv
// garp_mem_bus_master: sequences burst descriptors and 48-bit write beats onto the
//   Garp array memory bus, waits LAT cycles, and returns each column sample as a response.
// Latency: FETCH handshake at edge t -> drive visible t+1, sample end of t+LAT, rsp_valid at t+LAT+1.
// Backpressure: one beat in flight; wr_ready is low outside FETCH, and RESP holds until rsp_ready.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   burst_valid/ready/addr/len descriptor: first row and beats-minus-one
//   wr_valid/ready/data        write beats, column k in bits [BITS*k +: BITS]
//   rsp_valid/ready/data/addr/last  captured column outputs per beat
//   abort                      cancel the current burst (no done pulse)
//   busy, done                 status; done pulses once after the last response
//   io_addr, io_mem_bus_in_*   registered row address and column drive to the array
//   io_mem_bus_out_*           column results from the array
module garp_mem_bus_master #(
  parameter int COLS   = 24,
  parameter int BITS   = 2,
  parameter int ADDR_W = 5,
  parameter int LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   burst_valid,
  output logic                   burst_ready,
  input  logic [ADDR_W-1:0]      burst_addr,
  input  logic [ADDR_W-1:0]      burst_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [COLS*BITS-1:0]   wr_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [COLS*BITS-1:0]   rsp_data,
  output logic [ADDR_W-1:0]      rsp_addr,
  output logic                   rsp_last,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      io_addr,
  output logic [BITS-1:0]        io_mem_bus_in_0,
  output logic [BITS-1:0]        io_mem_bus_in_1,
  output logic [BITS-1:0]        io_mem_bus_in_2,
  output logic [BITS-1:0]        io_mem_bus_in_3,
  output logic [BITS-1:0]        io_mem_bus_in_4,
  output logic [BITS-1:0]        io_mem_bus_in_5,
  output logic [BITS-1:0]        io_mem_bus_in_6,
  output logic [BITS-1:0]        io_mem_bus_in_7,
  output logic [BITS-1:0]        io_mem_bus_in_8,
  output logic [BITS-1:0]        io_mem_bus_in_9,
  output logic [BITS-1:0]        io_mem_bus_in_10,
  output logic [BITS-1:0]        io_mem_bus_in_11,
  output logic [BITS-1:0]        io_mem_bus_in_12,
  output logic [BITS-1:0]        io_mem_bus_in_13,
  output logic [BITS-1:0]        io_mem_bus_in_14,
  output logic [BITS-1:0]        io_mem_bus_in_15,
  output logic [BITS-1:0]        io_mem_bus_in_16,
  output logic [BITS-1:0]        io_mem_bus_in_17,
  output logic [BITS-1:0]        io_mem_bus_in_18,
  output logic [BITS-1:0]        io_mem_bus_in_19,
  output logic [BITS-1:0]        io_mem_bus_in_20,
  output logic [BITS-1:0]        io_mem_bus_in_21,
  output logic [BITS-1:0]        io_mem_bus_in_22,
  output logic [BITS-1:0]        io_mem_bus_in_23,
  input  logic [BITS-1:0]        io_mem_bus_out_0,
  input  logic [BITS-1:0]        io_mem_bus_out_1,
  input  logic [BITS-1:0]        io_mem_bus_out_2,
  input  logic [BITS-1:0]        io_mem_bus_out_3,
  input  logic [BITS-1:0]        io_mem_bus_out_4,
  input  logic [BITS-1:0]        io_mem_bus_out_5,
  input  logic [BITS-1:0]        io_mem_bus_out_6,
  input  logic [BITS-1:0]        io_mem_bus_out_7,
  input  logic [BITS-1:0]        io_mem_bus_out_8,
  input  logic [BITS-1:0]        io_mem_bus_out_9,
  input  logic [BITS-1:0]        io_mem_bus_out_10,
  input  logic [BITS-1:0]        io_mem_bus_out_11,
  input  logic [BITS-1:0]        io_mem_bus_out_12,
  input  logic [BITS-1:0]        io_mem_bus_out_13,
  input  logic [BITS-1:0]        io_mem_bus_out_14,
  input  logic [BITS-1:0]        io_mem_bus_out_15,
  input  logic [BITS-1:0]        io_mem_bus_out_16,
  input  logic [BITS-1:0]        io_mem_bus_out_17,
  input  logic [BITS-1:0]        io_mem_bus_out_18,
  input  logic [BITS-1:0]        io_mem_bus_out_19,
  input  logic [BITS-1:0]        io_mem_bus_out_20,
  input  logic [BITS-1:0]        io_mem_bus_out_21,
  input  logic [BITS-1:0]        io_mem_bus_out_22,
  input  logic [BITS-1:0]        io_mem_bus_out_23
);

  localparam int W = COLS * BITS;
  // The wait counter is 4 bits wide, which covers the legal LAT range 1..15.
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   io_addr_q, io_addr_d;
  logic [W-1:0]        io_in_q, io_in_d;
  logic [W-1:0]        rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic                rsp_last_q, rsp_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [W-1:0]        bus_out;

  // Column results gathered into one word, column 0 in the low bits.
  assign bus_out = {io_mem_bus_out_23, io_mem_bus_out_22, io_mem_bus_out_21, io_mem_bus_out_20,
                    io_mem_bus_out_19, io_mem_bus_out_18, io_mem_bus_out_17, io_mem_bus_out_16,
                    io_mem_bus_out_15, io_mem_bus_out_14, io_mem_bus_out_13, io_mem_bus_out_12,
                    io_mem_bus_out_11, io_mem_bus_out_10, io_mem_bus_out_9,  io_mem_bus_out_8,
                    io_mem_bus_out_7,  io_mem_bus_out_6,  io_mem_bus_out_5,  io_mem_bus_out_4,
                    io_mem_bus_out_3,  io_mem_bus_out_2,  io_mem_bus_out_1,  io_mem_bus_out_0};

  // Abort gates both handshakes so a cancel never races with an accepted beat.
  assign burst_ready = (state_q == ST_IDLE);
  assign wr_ready    = (state_q == ST_FETCH) && !abort;
  assign rsp_valid   = (state_q == ST_RESP) && !abort;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    io_addr_d   = io_addr_q;
    io_in_d     = io_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (burst_valid) begin
          cur_addr_d  = burst_addr;
          remaining_d = burst_len;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wr_valid) begin
          io_addr_d  = cur_addr_q;
          io_in_d    = wr_data;
          wait_cnt_d = LAT_CNT;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          // The in-flight beat is dropped: no capture into the response registers.
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
          if (wait_cnt_q == 4'd1) begin
            rsp_data_d = bus_out;
            rsp_addr_d = cur_addr_q;
            state_d    = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rsp_ready) begin
          if (remaining_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d  = cur_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
            state_d     = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d     = (state_d != ST_IDLE);
    rsp_last_d = (state_d == ST_RESP) && (remaining_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      io_addr_q   <= '0;
      io_in_q     <= '0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      io_addr_q   <= io_addr_d;
      io_in_q     <= io_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_addr = rsp_addr_q;
  assign rsp_last = rsp_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign io_addr  = io_addr_q;

  assign io_mem_bus_in_0  = io_in_q[0*BITS  +: BITS];
  assign io_mem_bus_in_1  = io_in_q[1*BITS  +: BITS];
  assign io_mem_bus_in_2  = io_in_q[2*BITS  +: BITS];
  assign io_mem_bus_in_3  = io_in_q[3*BITS  +: BITS];
  assign io_mem_bus_in_4  = io_in_q[4*BITS  +: BITS];
  assign io_mem_bus_in_5  = io_in_q[5*BITS  +: BITS];
  assign io_mem_bus_in_6  = io_in_q[6*BITS  +: BITS];
  assign io_mem_bus_in_7  = io_in_q[7*BITS  +: BITS];
  assign io_mem_bus_in_8  = io_in_q[8*BITS  +: BITS];
  assign io_mem_bus_in_9  = io_in_q[9*BITS  +: BITS];
  assign io_mem_bus_in_10 = io_in_q[10*BITS +: BITS];
  assign io_mem_bus_in_11 = io_in_q[11*BITS +: BITS];
  assign io_mem_bus_in_12 = io_in_q[12*BITS +: BITS];
  assign io_mem_bus_in_13 = io_in_q[13*BITS +: BITS];
  assign io_mem_bus_in_14 = io_in_q[14*BITS +: BITS];
  assign io_mem_bus_in_15 = io_in_q[15*BITS +: BITS];
  assign io_mem_bus_in_16 = io_in_q[16*BITS +: BITS];
  assign io_mem_bus_in_17 = io_in_q[17*BITS +: BITS];
  assign io_mem_bus_in_18 = io_in_q[18*BITS +: BITS];
  assign io_mem_bus_in_19 = io_in_q[19*BITS +: BITS];
  assign io_mem_bus_in_20 = io_in_q[20*BITS +: BITS];
  assign io_mem_bus_in_21 = io_in_q[21*BITS +: BITS];
  assign io_mem_bus_in_22 = io_in_q[22*BITS +: BITS];
  assign io_mem_bus_in_23 = io_in_q[23*BITS +: BITS];

endmodule

// File: tb/tb_garp_mem_bus_master.sv
// tb_garp_mem_bus_master: directed and randomized bursts against a transaction-level
//   scoreboard (LAT=1 instance), plus an exact-timing check on a LAT=3 instance.
module tb_garp_mem_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  // ---------------- instance A: LAT=1 ----------------
  logic        burst_valid = 0, wr_valid = 0, rsp_ready = 0, abort = 0;
  logic [4:0]  burst_addr = 0, burst_len = 0;
  logic [47:0] wr_data = 0;
  wire         burst_ready, wr_ready, rsp_valid, rsp_last, busy, done;
  wire  [47:0] rsp_data;
  wire  [4:0]  rsp_addr, io_addr;
  wire  [47:0] io_in;
  logic [47:0] arr_out;
  bit          arr_const = 0;

  // Array model: either a constant pattern or a function of the current drive.
  always_comb arr_out = arr_const ? {24{2'b10}} : (~io_in ^ {43'b0, io_addr});

  garp_mem_bus_master #(.LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .burst_valid(burst_valid), .burst_ready(burst_ready), .burst_addr(burst_addr), .burst_len(burst_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_last(rsp_last),
    .abort(abort), .busy(busy), .done(done), .io_addr(io_addr),
    .io_mem_bus_in_0(io_in[1:0]), .io_mem_bus_in_1(io_in[3:2]), .io_mem_bus_in_2(io_in[5:4]), .io_mem_bus_in_3(io_in[7:6]),
    .io_mem_bus_in_4(io_in[9:8]), .io_mem_bus_in_5(io_in[11:10]), .io_mem_bus_in_6(io_in[13:12]), .io_mem_bus_in_7(io_in[15:14]),
    .io_mem_bus_in_8(io_in[17:16]), .io_mem_bus_in_9(io_in[19:18]), .io_mem_bus_in_10(io_in[21:20]), .io_mem_bus_in_11(io_in[23:22]),
    .io_mem_bus_in_12(io_in[25:24]), .io_mem_bus_in_13(io_in[27:26]), .io_mem_bus_in_14(io_in[29:28]), .io_mem_bus_in_15(io_in[31:30]),
    .io_mem_bus_in_16(io_in[33:32]), .io_mem_bus_in_17(io_in[35:34]), .io_mem_bus_in_18(io_in[37:36]), .io_mem_bus_in_19(io_in[39:38]),
    .io_mem_bus_in_20(io_in[41:40]), .io_mem_bus_in_21(io_in[43:42]), .io_mem_bus_in_22(io_in[45:44]), .io_mem_bus_in_23(io_in[47:46]),
    .io_mem_bus_out_0(arr_out[1:0]), .io_mem_bus_out_1(arr_out[3:2]), .io_mem_bus_out_2(arr_out[5:4]), .io_mem_bus_out_3(arr_out[7:6]),
    .io_mem_bus_out_4(arr_out[9:8]), .io_mem_bus_out_5(arr_out[11:10]), .io_mem_bus_out_6(arr_out[13:12]), .io_mem_bus_out_7(arr_out[15:14]),
    .io_mem_bus_out_8(arr_out[17:16]), .io_mem_bus_out_9(arr_out[19:18]), .io_mem_bus_out_10(arr_out[21:20]), .io_mem_bus_out_11(arr_out[23:22]),
    .io_mem_bus_out_12(arr_out[25:24]), .io_mem_bus_out_13(arr_out[27:26]), .io_mem_bus_out_14(arr_out[29:28]), .io_mem_bus_out_15(arr_out[31:30]),
    .io_mem_bus_out_16(arr_out[33:32]), .io_mem_bus_out_17(arr_out[35:34]), .io_mem_bus_out_18(arr_out[37:36]), .io_mem_bus_out_19(arr_out[39:38]),
    .io_mem_bus_out_20(arr_out[41:40]), .io_mem_bus_out_21(arr_out[43:42]), .io_mem_bus_out_22(arr_out[45:44]), .io_mem_bus_out_23(arr_out[47:46])
  );

  // ---------------- instance B: LAT=3 ----------------
  logic        b_burst_valid = 0, b_wr_valid = 0, b_rsp_ready = 0, b_abort = 0;
  logic [4:0]  b_burst_addr = 0, b_burst_len = 0;
  logic [47:0] b_wr_data = 0;
  wire         b_burst_ready, b_wr_ready, b_rsp_valid, b_rsp_last, b_busy, b_done;
  wire  [47:0] b_rsp_data, b_io_in;
  wire  [4:0]  b_rsp_addr, b_io_addr;
  logic [47:0] b_drv_q = 0;
  logic [47:0] b_arr_out;

  // Array output follows the drive one cycle late, tagged with the cycle number
  // so the sampled value reveals exactly which cycle was captured.
  always @(posedge clk) b_drv_q <= b_io_in;
  always_comb b_arr_out = b_drv_q ^ {44'b0, cyc[3:0]};

  garp_mem_bus_master #(.LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(reset),
    .burst_valid(b_burst_valid), .burst_ready(b_burst_ready), .burst_addr(b_burst_addr), .burst_len(b_burst_len),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_addr(b_rsp_addr), .rsp_last(b_rsp_last),
    .abort(b_abort), .busy(b_busy), .done(b_done), .io_addr(b_io_addr),
    .io_mem_bus_in_0(b_io_in[1:0]), .io_mem_bus_in_1(b_io_in[3:2]), .io_mem_bus_in_2(b_io_in[5:4]), .io_mem_bus_in_3(b_io_in[7:6]),
    .io_mem_bus_in_4(b_io_in[9:8]), .io_mem_bus_in_5(b_io_in[11:10]), .io_mem_bus_in_6(b_io_in[13:12]), .io_mem_bus_in_7(b_io_in[15:14]),
    .io_mem_bus_in_8(b_io_in[17:16]), .io_mem_bus_in_9(b_io_in[19:18]), .io_mem_bus_in_10(b_io_in[21:20]), .io_mem_bus_in_11(b_io_in[23:22]),
    .io_mem_bus_in_12(b_io_in[25:24]), .io_mem_bus_in_13(b_io_in[27:26]), .io_mem_bus_in_14(b_io_in[29:28]), .io_mem_bus_in_15(b_io_in[31:30]),
    .io_mem_bus_in_16(b_io_in[33:32]), .io_mem_bus_in_17(b_io_in[35:34]), .io_mem_bus_in_18(b_io_in[37:36]), .io_mem_bus_in_19(b_io_in[39:38]),
    .io_mem_bus_in_20(b_io_in[41:40]), .io_mem_bus_in_21(b_io_in[43:42]), .io_mem_bus_in_22(b_io_in[45:44]), .io_mem_bus_in_23(b_io_in[47:46]),
    .io_mem_bus_out_0(b_arr_out[1:0]), .io_mem_bus_out_1(b_arr_out[3:2]), .io_mem_bus_out_2(b_arr_out[5:4]), .io_mem_bus_out_3(b_arr_out[7:6]),
    .io_mem_bus_out_4(b_arr_out[9:8]), .io_mem_bus_out_5(b_arr_out[11:10]), .io_mem_bus_out_6(b_arr_out[13:12]), .io_mem_bus_out_7(b_arr_out[15:14]),
    .io_mem_bus_out_8(b_arr_out[17:16]), .io_mem_bus_out_9(b_arr_out[19:18]), .io_mem_bus_out_10(b_arr_out[21:20]), .io_mem_bus_out_11(b_arr_out[23:22]),
    .io_mem_bus_out_12(b_arr_out[25:24]), .io_mem_bus_out_13(b_arr_out[27:26]), .io_mem_bus_out_14(b_arr_out[29:28]), .io_mem_bus_out_15(b_arr_out[31:30]),
    .io_mem_bus_out_16(b_arr_out[33:32]), .io_mem_bus_out_17(b_arr_out[35:34]), .io_mem_bus_out_18(b_arr_out[37:36]), .io_mem_bus_out_19(b_arr_out[39:38]),
    .io_mem_bus_out_20(b_arr_out[41:40]), .io_mem_bus_out_21(b_arr_out[43:42]), .io_mem_bus_out_22(b_arr_out[45:44]), .io_mem_bus_out_23(b_arr_out[47:46])
  );

  // ---------------- transaction-level reference model for instance A ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [47:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mb;
  logic [4:0]  m_base = 0, m_len = 0;
  logic [5:0]  m_idx = 0;
  bit          pend_io = 0, done_exp = 0, hold_vld = 0, abort_seen = 0;
  logic [4:0]  pend_addr = 0, hold_addr = 0, abort_io = 0;
  logic [47:0] pend_data = 0, hold_data = 0;

  function automatic logic [47:0] exp_word(input logic [47:0] wr, input logic [4:0] a);
    if (arr_const) return {24{2'b10}};
    return ~wr ^ {43'b0, a};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend_io = 0; done_exp = 0; hold_vld = 0; abort_seen = 0;
    end else begin
      if (pend_io) begin
        chk("io_addr", io_addr, pend_addr);
        chk("io_in", io_in, pend_data);
        pend_io = 0;
      end
      chk("done", done, done_exp);
      if (done_exp) chk("done_busy", busy, 0);
      done_exp = 0;
      if (hold_vld && !abort) begin
        chk("hold_vld", rsp_valid, 1);
        chk("hold_data", rsp_data, hold_data);
        chk("hold_addr", rsp_addr, hold_addr);
      end
      hold_vld = 0;
      if (abort_seen) begin
        chk("abort_busy", busy, 0);
        chk("abort_rsp_vld", rsp_valid, 0);
        chk("abort_io_hold", io_addr, abort_io);
        abort_seen = 0;
      end
      if (abort && busy) begin
        exp_q.delete();
        abort_seen = 1;
        abort_io   = io_addr;
      end else begin
        if (burst_valid && burst_ready) begin
          m_base = burst_addr; m_len = burst_len; m_idx = 0;
        end
        if (wr_valid && wr_ready) begin
          mb.addr = m_base + m_idx[4:0];
          mb.data = exp_word(wr_data, mb.addr);
          mb.last = (m_idx[4:0] == m_len);
          exp_q.push_back(mb);
          m_idx++;
          pend_io = 1; pend_addr = mb.addr; pend_data = wr_data;
        end
        if (rsp_valid) begin
          if (rsp_ready) begin
            chk("rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              mb = exp_q.pop_front();
              chk("rsp_data", rsp_data, mb.data);
              chk("rsp_addr", rsp_addr, mb.addr);
              chk("rsp_last", rsp_last, mb.last);
              if (mb.last) done_exp = 1;
            end
          end else begin
            hold_vld = 1; hold_data = rsp_data; hold_addr = rsp_addr;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    burst_valid = 0; wr_valid = 0; rsp_ready = 0; abort = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one burst on instance A. bp: cycles to hold rsp_ready low at the first RESP.
  // abort_mode 1: abort in WAIT of beat 2; 2: abort together with rsp_ready on beat 1.
  // ign: re-offer a descriptor during WAIT cycles. lat: cycles from descriptor to done.
  task automatic run_burst(input logic [4:0] a, input logic [4:0] l, input bit stall, input int bp,
                           input int abort_mode, input bit ign, input logic [47:0] d0, input bit seq,
                           output int lat);
    bit in_burst = 0, got_end = 0, aborted = 0, wr_hs;
    int fetches = 0, guard = 0, cyc0 = 0;
    lat = -1;
    burst_valid = 1; burst_addr = a; burst_len = l; wr_data = d0;
    while (!got_end && guard < 3000) begin
      #1;
      wr_valid  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      rsp_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (in_burst && ign) begin
        burst_valid = busy && !wr_ready && !rsp_valid;
        burst_addr  = a ^ 5'h11;
      end
      if (bp > 0 && rsp_valid) begin
        rsp_ready = 0;
        bp--;
        chk("bp_no_fetch", wr_ready, 0);
      end
      if (abort_mode == 1 && !aborted && fetches == 2 && busy && !wr_ready && !rsp_valid) begin
        abort = 1; aborted = 1;
      end
      if (abort_mode == 2 && !aborted && fetches == 1 && rsp_valid) begin
        abort = 1; rsp_ready = 1; aborted = 1;
      end
      @(negedge clk);
      if (in_burst && burst_valid) chk("ign_burst_rdy", burst_ready, 0);
      if (burst_valid && burst_ready) begin
        in_burst = 1; cyc0 = cyc;
      end
      wr_hs = wr_valid && wr_ready;
      if (wr_hs) fetches++;
      if (done) begin
        got_end = 1; lat = cyc - cyc0;
      end
      if (aborted && !abort && !busy) got_end = 1;
      @(posedge clk);
      #1;
      abort = 0;
      if (in_burst) burst_valid = 0;
      if (wr_hs) wr_data = seq ? wr_data + 48'd1 : rnd48();
      guard++;
    end
    chk("burst_end", got_end, 1);
    burst_valid = 0; wr_valid = 0; rsp_ready = 0; abort = 0;
  endtask

  initial begin
    int lat;
    int bh, h, rise;
    logic [47:0] bd;
    logic [3:0]  hc;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_burst_ready", burst_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_io_addr", io_addr, 0);
    chk("rst_io_in", io_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_last", rsp_last, 0);
    reset = 0;
    idle(2);

    // single beat against a constant array pattern
    arr_const = 1;
    run_burst(5'd5, 5'd0, 0, 0, 0, 0, 48'h3, 1, lat);
    chk("single_lat", lat, 4);
    arr_const = 0;
    idle(2);

    // address wrap, data 1,2,3
    run_burst(5'd30, 5'd2, 0, 0, 0, 0, 48'h1, 1, lat);
    chk("wrap_lat", lat, 10);
    idle(2);

    // response backpressure for 5 cycles on the first beat
    run_burst(5'd10, 5'd2, 0, 5, 0, 0, rnd48(), 0, lat);
    chk("bp_lat", lat, 15);
    idle(2);

    // aborts: during WAIT of beat 2 of 4, and together with rsp_ready
    run_burst(5'd4, 5'd3, 0, 0, 1, 0, rnd48(), 0, lat);
    idle(4);
    run_burst(5'd8, 5'd3, 0, 0, 2, 0, rnd48(), 0, lat);
    idle(4);

    // descriptor offered while busy is ignored and not queued
    run_burst(5'd12, 5'd1, 0, 0, 0, 1, rnd48(), 0, lat);
    chk("ign_lat", lat, 7);
    idle(3);
    chk("ign_not_queued", busy, 0);

    // reset asserted while in FETCH
    burst_valid = 1; burst_addr = 5'd9; burst_len = 5'd3;
    @(posedge clk);
    #1;
    burst_valid = 0;
    #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_burst_ready", burst_ready, 1);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_io_addr", io_addr, 0);
    chk("mid_rst_io_in", io_in, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_rsp_addr", rsp_addr, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 0;
    idle(3);

    // randomized bursts with random wr_valid / rsp_ready stalls
    for (int i = 0; i < 25; i++) begin
      run_burst(5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)), 1, 0, 0, 0, rnd48(), 0, lat);
      idle($urandom_range(1, 3));
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    // LAT=3 exact timing on instance B
    b_burst_valid = 1; b_burst_addr = 5'd3; b_burst_len = 5'd0;
    @(negedge clk);
    bh = cyc;
    chk("b_burst_rdy", b_burst_ready, 1);
    @(posedge clk);
    #1;
    b_burst_valid = 0; b_wr_valid = 1; b_wr_data = rnd48(); bd = b_wr_data;
    @(negedge clk);
    h = cyc;
    chk("b_fetch_hs", b_wr_ready, 1);
    @(posedge clk);
    #1;
    b_wr_valid = 0; b_rsp_ready = 1;
    rise = -1;
    for (int k = 0; k < 10 && rise < 0; k++) begin
      @(negedge clk);
      if (b_rsp_valid) rise = cyc - h;
    end
    hc = 4'(h + 3);
    chk("b_rise", rise, 4);
    chk("b_data", b_rsp_data, bd ^ {44'b0, hc});
    chk("b_addr", b_rsp_addr, 5'd3);
    chk("b_last", b_rsp_last, 1);
    @(negedge clk);
    chk("b_done", b_done, 1);
    chk("b_lat", cyc - bh, 6);
    @(posedge clk);
    #1;
    b_rsp_ready = 0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/garp_mem_bus_master.md
# garp_mem_bus_master

Host-side sequencer for the Garp array memory bus. It accepts a burst descriptor and a stream of 48-bit data beats. For each beat it drives the array's row address and the 24 two-bit column inputs, waits a fixed array latency, and captures the 24 two-bit column outputs as a response beat. It sits between the host/DMA interface and GarpAccel, feeding `io_addr`/`io_mem_bus_in_*` and consuming `io_mem_bus_out_*`.

## Interface
- `COLS`, 24, number of bus columns.
- `BITS`, 2, bits per column; word width W = COLS*BITS = 48.
- `ADDR_W`, 5, row address width; addresses wrap modulo 2^ADDR_W.
- `LAT`, 1, cycles from drive-visible to sample; legal range 1..15.

Ports (all synchronous to `clk`):
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `burst_valid` in 1: burst descriptor offered.
- `burst_ready` out 1: high only in IDLE.
- `burst_addr` in ADDR_W: first row address.
- `burst_len` in ADDR_W: beats minus one (0 means 1 beat, 31 means 32 beats).
- `wr_valid` in 1: data beat offered.
- `wr_ready` out 1: high only in FETCH and when `abort` is low.
- `wr_data` in W: beat; column k uses bits [BITS*k+1 : BITS*k].
- `rsp_valid` out 1: response beat valid; high only in RESP and when `abort` is low.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out W: captured `io_mem_bus_out_*`, column k at bits [BITS*k+1 : BITS*k].
- `rsp_addr` out ADDR_W: row address of the current response.
- `rsp_last` out 1: high with the final beat of a burst.
- `abort` in 1: synchronous burst cancel.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse after the last response is accepted.
- `io_addr` out ADDR_W: registered row address to the array.
- `io_mem_bus_in_0` … `io_mem_bus_in_23` out BITS each: registered column drive.
- `io_mem_bus_out_0` … `io_mem_bus_out_23` in BITS each: column results from the array.

## Operation
- States: IDLE, FETCH, WAIT, RESP.
- **Reset** (asynchronous):
  - state = IDLE.
  - `io_addr`, `io_mem_bus_in_*`, `rsp_data`, `rsp_addr`, cur_addr, remaining and wait_cnt all = 0.
  - `done` = 0, `busy` = 0, `rsp_last` = 0, `rsp_valid` = 0, `wr_ready` = 0.
  - `burst_ready` = 1.
- **IDLE**: on `burst_valid`&`burst_ready`, set cur_addr = `burst_addr`, remaining = `burst_len`, then go to FETCH.
- **FETCH**: on `wr_valid`&`wr_ready`:
  - `io_addr` <= cur_addr.
  - `io_mem_bus_in_k` <= `wr_data` slice k.
  - wait_cnt <= LAT.
  - go to WAIT.
- **WAIT**:
  - wait_cnt decrements each cycle.
  - In the cycle wait_cnt == 1: `rsp_data` <= `io_mem_bus_out_*`, `rsp_addr` <= cur_addr, then go to RESP.
- **RESP**: `rsp_valid` = 1 and `rsp_last` = (remaining == 0). On `rsp_ready`:
  - If remaining == 0: go to IDLE and pulse `done` the next cycle.
  - Otherwise: cur_addr <= cur_addr+1 mod 2^ADDR_W, remaining <= remaining-1, go to FETCH.
- `io_addr` and `io_mem_bus_in_*` change only on a FETCH handshake; they hold between beats and after the burst ends.
- `rsp_data` and `rsp_addr` hold stable while `rsp_valid` is high and not yet accepted.
- **abort** (any non-IDLE state): go to IDLE next cycle. No `done` pulse. The in-flight beat is discarded. `io_*` outputs hold their last values.
- When `abort` coincides with a FETCH or RESP handshake, abort wins. `wr_ready` and `rsp_valid` are gated low, so no handshake occurs.
- `abort` in IDLE has no effect.
- `burst_valid` outside IDLE is ignored and is not queued.

## Timing
- A FETCH handshake at edge t makes the drive visible in cycle t+1.
- The array output is sampled at the end of cycle t+LAT.
- `rsp_valid` rises in cycle t+LAT+1.
- Minimum beat period is LAT+2 cycles (FETCH 1, WAIT LAT, RESP 1), with `wr_valid` and `rsp_ready` held high.
- For a burst of N beats with no stalls, there are 1 + N·(LAT+2) cycles from the `burst_valid` handshake to `done`.
- `done` is high for exactly one cycle, the cycle after the last RESP handshake. `busy` is low in that cycle.
- `burst_ready` is combinational from state; `wr_ready` and `rsp_valid` are combinational from state and `abort`. All other outputs are registered.
- Reset asserted mid-burst takes effect immediately (asynchronously), with all outputs at their reset values.

## Test plan
- **Single beat**:
  - Stimulus: LAT=1, burst addr=5, len=0, `wr_data`=0x0000_0000_0003; array model returns all columns = 2'b10.
  - Response: `io_addr`=5 and `io_mem_bus_in_0`=3 one cycle after the FETCH handshake; `rsp_data`=0xAAAA_AAAA_AAAA with `rsp_last`=1; then a `done` pulse, 4 cycles after the burst handshake.
- **Wrap burst**:
  - Stimulus: addr=30, len=2, data 1,2,3.
  - Response: `io_addr` sequence 30, 31, 0; `rsp_addr` 30, 31, 0; `rsp_last` only on the third beat.
- **Backpressure**:
  - Stimulus: hold `rsp_ready` low 5 cycles in RESP.
  - Response: `rsp_valid`, `rsp_data` and `rsp_addr` stay stable; no FETCH occurs; on release the next beat proceeds.
- **LAT=3 timing**:
  - Stimulus: array model changes its output one cycle after the drive.
  - Response: the sample is taken at the end of cycle t+3; `rsp_valid` rises at t+4.
- **Abort**:
  - Stimulus: assert `abort` during WAIT of beat 2 of 4; separately, assert `abort` coinciding with `rsp_ready`.
  - Response: IDLE next cycle; `busy`=0; no `done` pulse; `rsp_valid` low; `io_addr` holds.
- **Reset mid-burst / ignore**:
  - Stimulus: assert `reset` in FETCH; also assert `burst_valid` while busy.
  - Response: all outputs go to 0 immediately and `burst_ready`=1 with no spurious `done`; the busy-time descriptor is ignored.
